// File: rtl/fp_to_fixed_conv_if.sv
// Valid/ready stream bundle for the float-to-fixed converter.
// FP2FIX_SAT_FLAG_EN adds the per-word saturation flag on the master side.
interface fp_to_fixed_conv_if #(parameter int W = 32);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
`ifdef FP2FIX_SAT_FLAG_EN
  logic         sat;
  modport master (output data, valid, sat, input ready);
`else
  modport master (output data, valid, input ready);
`endif
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/fp_to_fixed_conv.sv
// Two-stage float-to-fixed converter: S1 unpacks {sign,exp,man}, S2 shifts/rounds/saturates.
// Optional macro FP2FIX_SAT_FLAG_EN exports a registered saturation flag on out_m.sat.
module fp_to_fixed_conv #(
  parameter int EXPONENT   = 8,
  parameter int MANTISSA   = 23,
  parameter int FIX_WIDTH  = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_to_fixed_conv_if.slave    in_s,
  fp_to_fixed_conv_if.master   out_m
);
  localparam int BIAS   = 2**(EXPONENT-1) - 1;
  localparam int SH_OFS = BIAS - FRAC_WIDTH + MANTISSA;
  localparam int WIDE   = MANTISSA + FIX_WIDTH + 2;
  localparam logic [WIDE-1:0] LIM_POS = {{(WIDE-FIX_WIDTH+1){1'b0}}, {(FIX_WIDTH-1){1'b1}}};
  localparam logic [WIDE-1:0] LIM_NEG = LIM_POS + 1'b1;

  logic [2:1]                 vld_pipe;
  logic                       s1_adv, s2_adv;

  logic                       s1_sign, s1_zero, s1_inf;
  logic [MANTISSA:0]          s1_mag;
  logic signed [EXPONENT+1:0] s1_sh;

  logic [FIX_WIDTH-1:0]       out_data_q, res;
  logic [WIDE-1:0]            mag_w;
  logic                       big, ovf;
  int                         sh_i;
`ifdef FP2FIX_SAT_FLAG_EN
  logic                       sat_q, res_sat;
`endif

  wire                        in_sign = in_s.data[EXPONENT+MANTISSA];
  wire [EXPONENT-1:0]         in_exp  = in_s.data[EXPONENT+MANTISSA-1:MANTISSA];
  wire [MANTISSA-1:0]         in_man  = in_s.data[MANTISSA-1:0];

  assign s2_adv     = !vld_pipe[2] || out_m.ready;
  assign s1_adv     = !vld_pipe[1] || s2_adv;
  assign in_s.ready = s1_adv;

  always_ff @(posedge clk) begin
    if (s1_adv && in_s.valid) begin
      s1_sign <= in_sign;
      s1_zero <= (in_exp == '0);
      s1_inf  <= (in_exp == '1);
      s1_mag  <= {1'b1, in_man};
      s1_sh   <= $signed({2'b00, in_exp}) - (EXPONENT+2)'(SH_OFS);
    end
  end

  // Overflow is decided on the full-width magnitude, before truncation to FIX_WIDTH.
  always_comb begin
    mag_w = '0;
    big   = 1'b0;
    sh_i  = int'(s1_sh);
    if (sh_i >= 0) begin
      if (sh_i >= FIX_WIDTH) big = 1'b1;
      else                   mag_w = WIDE'(s1_mag) << sh_i;
    end else if (-sh_i < MANTISSA + 2) begin
      mag_w = (WIDE'(s1_mag) + (WIDE'(1) << (-sh_i - 1))) >> (-sh_i);
    end
    ovf = big || (s1_sign ? (mag_w > LIM_NEG) : (mag_w > LIM_POS));
    res = s1_sign ? -mag_w[FIX_WIDTH-1:0] : mag_w[FIX_WIDTH-1:0];
    if (s1_zero)             res = '0;
    else if (s1_inf || ovf)  res = s1_sign ? {1'b1, {(FIX_WIDTH-1){1'b0}}}
                                           : {1'b0, {(FIX_WIDTH-1){1'b1}}};
`ifdef FP2FIX_SAT_FLAG_EN
    res_sat = !s1_zero && (s1_inf || ovf);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      out_data_q <= '0;
`ifdef FP2FIX_SAT_FLAG_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data_q <= res;
`ifdef FP2FIX_SAT_FLAG_EN
          sat_q      <= res_sat;
`endif
        end
      end
      if (s1_adv) vld_pipe[1] <= in_s.valid;
    end
  end

  assign out_m.data  = out_data_q;
  assign out_m.valid = vld_pipe[2];
`ifdef FP2FIX_SAT_FLAG_EN
  assign out_m.sat   = sat_q;
`endif
endmodule

// File: tb/tb_fp_to_fixed_conv.sv
// Directed bench for fp_to_fixed_conv: single conversions, back-pressure stream, mid-flight reset.
module tb_fp_to_fixed_conv;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fp_to_fixed_conv_if #(.W(32)) in_if ();
  fp_to_fixed_conv_if #(.W(32)) out_if ();

  fp_to_fixed_conv #(.EXPONENT(8), .MANTISSA(23), .FIX_WIDTH(32), .FRAC_WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_s  (in_if),
    .out_m (out_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One word through an idle pipe with out_ready held high.
  task automatic convert(input string tag, input logic [31:0] word,
                         input logic [31:0] exp, input logic exp_sat);
    @(negedge clk);
    in_if.valid = 1'b1; in_if.data = word; out_if.ready = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_if.ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_if.valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_if.valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_if.valid), 32'd1);
    chk({tag, "_data"}, out_if.data, exp);
`ifdef FP2FIX_SAT_FLAG_EN
    chk({tag, "_sat"}, 32'(out_if.sat), 32'(exp_sat));
`else
    if (exp_sat) ;
`endif
  endtask

  logic [31:0] vals [4];
  logic [31:0] got_q[$];
  int          idx;

  initial begin
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
    vals[2] = 32'h40400000; vals[3] = 32'h40800000;
    rst = 1'b1; in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("rst_out_data", out_if.data, 32'h0);
    chk("rst_in_ready", 32'(in_if.ready), 32'd1);
`ifdef FP2FIX_SAT_FLAG_EN
    chk("rst_out_sat", 32'(out_if.sat), 32'd0);
`endif

    convert("one",      32'h3F800000, 32'h00010000, 1'b0);
    convert("m2p5",     32'hC0200000, 32'hFFFD8000, 1'b0);
    convert("pzero",    32'h00000000, 32'h00000000, 1'b0);
    convert("nzero",    32'h80000000, 32'h00000000, 1'b0);
    convert("m0p5",     32'hBF000000, 32'hFFFF8000, 1'b0);
    convert("two_m17",  32'h37000000, 32'h00000001, 1'b0);
    convert("two_m18",  32'h36800000, 32'h00000000, 1'b0);
    convert("p65536",   32'h47800000, 32'h7FFFFFFF, 1'b1);
    convert("m32768",   32'hC7000000, 32'h80000000, 1'b0);
    convert("pinf",     32'h7F800000, 32'h7FFFFFFF, 1'b1);
    convert("ninf",     32'hFF800000, 32'h80000000, 1'b1);

    // Stream of four words with out_ready low for cycles 0..4.
    idx = 0;
    got_q.delete();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_if.ready = (c >= 5);
      in_if.valid  = (idx < 4);
      in_if.data   = (idx < 4) ? vals[idx] : 32'h0;
      #1;
      if (c >= 2 && c <= 4) begin
        chk("bp_in_ready", 32'(in_if.ready), 32'd0);
        chk("bp_valid", 32'(out_if.valid), 32'd1);
        chk("bp_hold", out_if.data, 32'h00010000);
      end
      if (in_if.valid && in_if.ready) idx++;
      if (out_if.valid && out_if.ready) got_q.push_back(out_if.data);
    end
    in_if.valid = 1'b0;
    chk("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("bp_order", got_q[i], (i + 1) << 16);

    // Two words in flight, then a one-cycle reset.
    @(negedge clk);
    out_if.ready = 1'b0; in_if.valid = 1'b1; in_if.data = 32'h3F800000;
    @(negedge clk);
    in_if.data = 32'h40000000;
    @(negedge clk);
    in_if.valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_out_valid", 32'(out_if.valid), 32'd0);
    chk("mrst_in_ready", 32'(in_if.ready), 32'd1);
    got_q.delete();
    out_if.ready = 1'b1; in_if.valid = 1'b1; in_if.data = 32'h40400000;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_if.valid && out_if.ready) got_q.push_back(out_if.data);
      @(negedge clk);
      in_if.valid = 1'b0;
    end
    chk("mrst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("mrst_data", got_q[0], 32'h00030000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
